ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Parametrised instruction-fetch stage for the LoongArch pipeline. It replaces the single-register fetch stage with three parts: a PC generator, a request/response SRAM-like fetch port (addr_ok/data_ok), and an in-order instruction buffer of configurable depth. It keeps multiple fetches in flight, absorbs decode back-pressure, and cleanly cancels in-flight fetches on branch, exception or ertn redirects. It sits between the instruction SRAM bridge and the ID stage.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset
- BUF_DEPTH, 4, instruction buffer entries; power of 2, ≥2
- MAX_OUTST, 2, max fetch requests accepted but not yet answered (including cancelled ones); 1..BUF_DEPTH

Ports:
- clk  in  1  clock
- resetn  in  1  reset resetn, synchronous, active-low
- id_allowin  in  1  ID can accept an instruction this cycle
- if_id_valid  out  1  head entry valid toward ID
- if_id_bus  out  64  {pc[31:0], inst[31:0]} of head entry
- br_taken  in  1  ID branch redirect
- br_target  in  32  branch target
- flush  in  1  WB exception or ertn redirect
- flush_target  in  32  exception entry / ERA
- inst_sram_req  out  1  fetch request
- inst_sram_addr  out  32  fetch address
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  response valid this cycle; responses return in request order
- inst_sram_rdata  in  32  response instruction

## Operation
- Fetch PC register `fpc` holds the address of the next request.
- A request is accepted when req && addr_ok. On acceptance: allocate a buffer entry at the tail with pc=fpc and filled=0, then fpc += 4.
- inst_sram_req = 1 only when all of the following hold: not in reset, no redirect this cycle, allocated entries < BUF_DEPTH, and outstanding + cancel_cnt < MAX_OUTST.
- addr is held stable while req is high and not accepted.
- On data_ok:
  - if cancel_cnt > 0, decrement it and drop the data;
  - otherwise, write rdata into the oldest unfilled entry and set its filled flag.
- Head pops when the head entry is filled and id_allowin = 1.
- if_id_valid = head allocated && filled.
- Redirect sources: flush has priority over br_taken. The target is flush_target if flush, else br_target.
- On redirect:
  - fpc ← target;
  - all buffer entries are discarded (head = tail, count 0);
  - cancel_cnt ← cancel_cnt + outstanding responses not yet returned, including a request accepted in the same cycle, minus any data_ok arriving that cycle;
  - outstanding ← 0;
  - if_id_valid forced to 0 in the redirect cycle.
- Simultaneous pop and allocate leaves the count unchanged. Pointers are log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH.
- Counter widths are sized for MAX_OUTST. cancel_cnt never exceeds MAX_OUTST.

## Timing
- Reset values: if_id_valid = 0, inst_sram_req = 0, inst_sram_addr = RESET_PC, all counters and pointers = 0, fpc = RESET_PC.
- The first request (addr RESET_PC) is asserted in the first cycle after resetn rises.
- A response written on a data_ok cycle is visible on if_id_valid/if_id_bus the next cycle: fetch-to-ID latency is 1 cycle after data_ok.
- Redirect in cycle T: no request in T; a request to the target is asserted in T+1. The earliest new instruction reaches ID one cycle after its data_ok.
- Full buffer with id_allowin = 0: req stays low and no entry is overwritten.
- Reset mid-operation discards everything including cancel_cnt. Responses to pre-reset requests are the bridge's responsibility (the bridge is reset together with this block).

## Configuration
- IFQ_BYPASS_EN defined: when the buffer holds exactly one entry, that entry is unfilled, data_ok arrives with cancel_cnt = 0, and no redirect occurs, then rdata is forwarded combinationally onto if_id_bus with if_id_valid = 1 in the same cycle. If id_allowin = 1 the entry pops immediately (0-cycle latency). Otherwise the entry is filled normally.
- IFQ_BYPASS_EN undefined: the 1-cycle latency above always applies.

## Test plan
- Reset then addr_ok/data_ok always 1, id_allowin = 1 → requests 0x1c000000, 0x1c000004, 0x1c000008…; ID receives the same PCs in order, one per cycle after the pipeline fills.
- id_allowin = 0 for 10 cycles, BUF_DEPTH = 4 → exactly 4 requests accepted, then req low. Release → 4 instructions delivered back-to-back in order, then fetching resumes.
- Two requests in flight, br_taken = 1 with br_target = 0x1c000100 → both later data_ok responses dropped (cancel_cnt 2→0); the next instruction seen by ID has pc 0x1c000100.
- flush and br_taken asserted in the same cycle (flush_target = 0x1c008000, br_target = 0x1c000200) → fetch continues from 0x1c008000; no 0x1c000200 request is issued.
- Redirect in the same cycle as addr_ok and data_ok → cancel_cnt accounts for both correctly; no stale instruction reaches ID.
- addr_ok delayed 3 cycles → addr stable and req held high; no duplicate allocation occurs.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: PC generator, addr_ok/data_ok fetch port and in-order instruction buffer.
// Optional IFQ_BYPASS_EN forwards a response straight to ID when it lands on the sole, unfilled entry.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  output logic        if_id_valid,
  output logic [63:0] if_id_bus,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [OW:0]   MAXO_C  = (OW + 1)'(MAX_OUTST);

  logic [31:0]          fpc;
  logic [31:0]          pc_q   [BUF_DEPTH];
  logic [31:0]          inst_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] filled;
  logic [PW-1:0]        head, tail, fptr;
  logic [CW-1:0]        count, count_nxt;
  logic [OW-1:0]        outst, outst_nxt;
  logic [OW-1:0]        cancel, cancel_nxt;

  logic        redirect;
  logic [31:0] target;
  logic        acc, live_rsp, take, bypass, bypass_pop, write_en, pop;
  logic [OW:0] inflight, inflight_nxt, outst_sum;

  assign redirect = flush | br_taken;
  assign target   = flush ? flush_target : br_target;

  // outstanding + cancel_cnt together bound every request the bridge still owes us
  assign inflight = {1'b0, outst} + {1'b0, cancel};

  assign inst_sram_req  = resetn & ~redirect & (count < DEPTH_C) & (inflight < MAXO_C);
  assign inst_sram_addr = fpc;

  assign acc      = inst_sram_req & inst_sram_addr_ok;
  assign live_rsp = inst_sram_data_ok & (cancel == '0);
  assign take     = live_rsp & ~redirect;

`ifdef IFQ_BYPASS_EN
  assign bypass = take && (count == CW'(1)) && !filled[head];
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    if_id_valid = 1'b0;
    if_id_bus   = {pc_q[head], inst_q[head]};
    if (resetn && !redirect) begin
      if (bypass) begin
        if_id_valid = 1'b1;
        if_id_bus   = {pc_q[head], inst_sram_rdata};
      end else begin
        if_id_valid = (count != '0) && filled[head];
      end
    end
  end

  assign pop        = if_id_valid & id_allowin;
  assign bypass_pop = bypass & id_allowin;
  assign write_en   = take & ~bypass_pop;

  // A redirect folds every still-owed response (minus the one returning now) into cancel_cnt
  always_comb begin
    inflight_nxt = inflight + {{OW{1'b0}}, acc} - {{OW{1'b0}}, inst_sram_data_ok};
    outst_sum    = {1'b0, outst} + {{OW{1'b0}}, acc} - {{OW{1'b0}}, live_rsp};
    cancel_nxt   = cancel;
    outst_nxt    = outst;
    if (redirect) begin
      cancel_nxt = inflight_nxt[OW-1:0];
      outst_nxt  = '0;
    end else begin
      if (inst_sram_data_ok && (cancel != '0))
        cancel_nxt = cancel - OW'(1);
      outst_nxt = outst_sum[OW-1:0];
    end
  end

  always_comb begin
    count_nxt = count + {{PW{1'b0}}, acc} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fpc    <= RESET_PC;
      head   <= '0;
      tail   <= '0;
      fptr   <= '0;
      count  <= '0;
      outst  <= '0;
      cancel <= '0;
      filled <= '0;
    end else begin
      outst  <= outst_nxt;
      cancel <= cancel_nxt;
      if (redirect) begin
        fpc    <= target;
        head   <= tail;
        fptr   <= tail;
        count  <= '0;
        filled <= '0;
      end else begin
        if (acc) begin
          filled[tail] <= 1'b0;
          tail         <= tail + PW'(1);
          fpc          <= fpc + 32'd4;
        end
        if (write_en)
          filled[fptr] <= 1'b1;
        if (take)
          fptr <= fptr + PW'(1);
        if (pop)
          head <= head + PW'(1);
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !redirect) begin
      if (acc)
        pc_q[tail] <= fpc;
      if (write_en)
        inst_q[fptr] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: behavioural bridge + queue-level reference model.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC  = 32'h1c000000;
  localparam int          BUF_DEPTH = 4;
  localparam int          MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        id_allowin = 1'b0;
  logic        br_taken = 1'b0;
  logic        flush = 1'b0;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] flush_target = '0;
  logic [31:0] rdata = '0;
  logic        if_id_valid;
  logic [63:0] if_id_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;

  int tests_run = 0;
  int tests_failed = 0;
  int dok_rate = 100;

  logic [31:0] bq_addr [$];
  bit          bq_live [$];
  logic [31:0] mq_pc [$];
  bit          mq_filled [$];
  logic [31:0] mfpc = RESET_PC;
  logic [31:0] delivered [$];
  logic [31:0] accepted [$];

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .resetn(resetn), .id_allowin(id_allowin),
    .if_id_valid(if_id_valid), .if_id_bus(if_id_bus),
    .br_taken(br_taken), .br_target(br_target),
    .flush(flush), .flush_target(flush_target),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h13579bdf;
  endfunction

  // One clock: bridge drives data_ok, model predicts req/valid/bus, then advances.
  task automatic cycle();
    bit redir, exp_req, live, byp, exp_valid;
    logic [31:0] tgt;
    logic [63:0] exp_bus;
    if (bq_addr.size() != 0 && $urandom_range(99) < dok_rate) begin
      data_ok = 1'b1;
      rdata   = inst_of(bq_addr[0]);
    end else begin
      data_ok = 1'b0;
      rdata   = $urandom;
    end
    @(negedge clk);
    redir   = flush | br_taken;
    tgt     = flush ? flush_target : br_target;
    exp_req = !redir && (mq_pc.size() < BUF_DEPTH) && (bq_addr.size() < MAX_OUTST);
    tests_run++;
    if (inst_sram_req !== exp_req) begin
      tests_failed++;
      $display("FAIL req @%0t: got %b expected %b", $time, inst_sram_req, exp_req);
    end
    if (exp_req) begin
      tests_run++;
      if (inst_sram_addr !== mfpc) begin
        tests_failed++;
        $display("FAIL addr @%0t: got %h expected %h", $time, inst_sram_addr, mfpc);
      end
    end
    live = 1'b0;
    if (data_ok) begin
      live = bq_live[0] && !redir;
      void'(bq_addr.pop_front());
      void'(bq_live.pop_front());
    end
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = live && (mq_pc.size() == 1) && !mq_filled[0];
`endif
    exp_valid = !redir && ((mq_pc.size() != 0 && mq_filled[0]) || byp);
    tests_run++;
    if (if_id_valid !== exp_valid) begin
      tests_failed++;
      $display("FAIL valid @%0t: got %b expected %b", $time, if_id_valid, exp_valid);
    end
    if (exp_valid) begin
      exp_bus = {mq_pc[0], inst_of(mq_pc[0])};
      tests_run++;
      if (if_id_bus !== exp_bus) begin
        tests_failed++;
        $display("FAIL bus @%0t: got %h expected %h", $time, if_id_bus, exp_bus);
      end
    end
    if (inst_sram_req && addr_ok) begin
      accepted.push_back(inst_sram_addr);
      bq_addr.push_back(inst_sram_addr);
      bq_live.push_back(1'b1);
    end
    if (redir) begin
      foreach (bq_live[i]) bq_live[i] = 1'b0;
      mq_pc.delete();
      mq_filled.delete();
      mfpc = tgt;
    end else begin
      if (exp_valid && id_allowin) delivered.push_back(mq_pc[0]);
      if (live) begin
        if (byp && id_allowin) begin
          void'(mq_pc.pop_front());
          void'(mq_filled.pop_front());
        end else begin
          for (int i = 0; i < mq_pc.size(); i++)
            if (!mq_filled[i]) begin
              mq_filled[i] = 1'b1;
              break;
            end
        end
      end
      if (exp_valid && id_allowin && !byp) begin
        void'(mq_pc.pop_front());
        void'(mq_filled.pop_front());
      end
      if (exp_req && addr_ok) begin
        mq_pc.push_back(mfpc);
        mq_filled.push_back(1'b0);
        mfpc = mfpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; br_taken = 1'b0; flush = 1'b0;
    addr_ok = 1'b0; id_allowin = 1'b0; data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    bq_addr.delete(); bq_live.delete();
    mq_pc.delete(); mq_filled.delete();
    delivered.delete(); accepted.delete();
    mfpc = RESET_PC;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; data_ok = 1'b0; br_taken = 1'b0; flush = 1'b0;
    @(posedge clk);
    #2;
    tests_run++;
    if (inst_sram_req !== 1'b0 || if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: req=%b valid=%b expected 0 0", inst_sram_req, if_id_valid);
    end
    tests_run++;
    if (inst_sram_addr !== RESET_PC) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h expected %h", inst_sram_addr, RESET_PC);
    end
    apply_reset();
    tests_run++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC || if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_req: req=%b addr=%h valid=%b expected 1 %h 0",
               inst_sram_req, inst_sram_addr, if_id_valid, RESET_PC);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    addr_ok = 1'b1; id_allowin = 1'b1; dok_rate = 100;
    repeat (30) cycle();
    tests_run++;
    if (delivered.size() < 28) begin
      tests_failed++;
      $display("FAIL stream_rate: got %0d delivered expected >= 28", delivered.size());
    end
    for (int i = 0; i < 8 && i < delivered.size(); i++) begin
      tests_run++;
      if (delivered[i] !== RESET_PC + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL stream_pc[%0d]: got %h expected %h", i, delivered[i], RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    addr_ok = 1'b1; id_allowin = 1'b0; dok_rate = 100;
    repeat (10) cycle();
    tests_run++;
    if (accepted.size() != BUF_DEPTH || inst_sram_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_stall: accepted=%0d req=%b expected %0d 0", accepted.size(), inst_sram_req, BUF_DEPTH);
    end
    id_allowin = 1'b1;
    repeat (4) cycle();
    tests_run++;
    if (delivered.size() != 4) begin
      tests_failed++;
      $display("FAIL drain_count: got %0d expected 4", delivered.size());
    end
    for (int i = 0; i < 4 && i < delivered.size(); i++) begin
      tests_run++;
      if (delivered[i] !== RESET_PC + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL drain_pc[%0d]: got %h expected %h", i, delivered[i], RESET_PC + 32'(4 * i));
      end
    end
    repeat (6) cycle();
    tests_run++;
    if (accepted.size() <= BUF_DEPTH) begin
      tests_failed++;
      $display("FAIL resume: accepted=%0d expected > %0d", accepted.size(), BUF_DEPTH);
    end
  endtask

  task automatic test_branch_cancel();
    apply_reset();
    addr_ok = 1'b1; id_allowin = 1'b1; dok_rate = 0;
    repeat (3) cycle();
    tests_run++;
    if (bq_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL inflight_setup: got %0d expected 2", bq_addr.size());
    end
    br_taken = 1'b1; br_target = 32'h1c000100;
    cycle();
    br_taken = 1'b0; dok_rate = 100;
    delivered.delete(); accepted.delete();
    repeat (12) cycle();
    tests_run++;
    if (accepted.size() == 0 || accepted[0] !== 32'h1c000100) begin
      tests_failed++;
      $display("FAIL br_first_req: got %h expected %h", accepted.size() ? accepted[0] : 32'hx, 32'h1c000100);
    end
    tests_run++;
    if (delivered.size() == 0 || delivered[0] !== 32'h1c000100) begin
      tests_failed++;
      $display("FAIL br_first_inst: got %h expected %h", delivered.size() ? delivered[0] : 32'hx, 32'h1c000100);
    end
  endtask

  task automatic test_flush_priority();
    int bad;
    apply_reset();
    addr_ok = 1'b1; id_allowin = 1'b1; dok_rate = 100;
    repeat (5) cycle();
    flush = 1'b1; flush_target = 32'h1c008000;
    br_taken = 1'b1; br_target = 32'h1c000200;
    cycle();
    flush = 1'b0; br_taken = 1'b0;
    delivered.delete(); accepted.delete();
    repeat (15) cycle();
    tests_run++;
    if (accepted.size() == 0 || accepted[0] !== 32'h1c008000) begin
      tests_failed++;
      $display("FAIL flush_first_req: got %h expected %h", accepted.size() ? accepted[0] : 32'hx, 32'h1c008000);
    end
    bad = 0;
    foreach (accepted[i]) if (accepted[i] == 32'h1c000200) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL flush_no_br_req: got %0d requests to br_target expected 0", bad);
    end
    tests_run++;
    if (delivered.size() == 0 || delivered[0] !== 32'h1c008000) begin
      tests_failed++;
      $display("FAIL flush_first_inst: got %h expected %h", delivered.size() ? delivered[0] : 32'hx, 32'h1c008000);
    end
  endtask

  task automatic test_redirect_same_cycle();
    apply_reset();
    addr_ok = 1'b1; id_allowin = 1'b0; dok_rate = 0;
    repeat (2) cycle();
    br_taken = 1'b1; br_target = 32'h1c000300; addr_ok = 1'b1; dok_rate = 100;
    cycle();
    br_taken = 1'b0; id_allowin = 1'b1;
    delivered.delete();
    repeat (15) cycle();
    tests_run++;
    if (delivered.size() < 4) begin
      tests_failed++;
      $display("FAIL same_cycle_count: got %0d expected >= 4", delivered.size());
    end
    foreach (delivered[i]) begin
      tests_run++;
      if (delivered[i] !== 32'h1c000300 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL same_cycle_pc[%0d]: got %h expected %h", i, delivered[i], 32'h1c000300 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_addr_stall();
    apply_reset();
    addr_ok = 1'b0; id_allowin = 1'b1; dok_rate = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (inst_sram_req !== 1'b1 || inst_sram_addr !== RESET_PC) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: req=%b addr=%h expected 1 %h", i, inst_sram_req, inst_sram_addr, RESET_PC);
      end
    end
    addr_ok = 1'b1;
    cycle();
    addr_ok = 1'b0;
    #1;
    tests_run++;
    if (accepted.size() != 1 || inst_sram_addr !== RESET_PC + 32'd4) begin
      tests_failed++;
      $display("FAIL stall_single_alloc: accepted=%0d addr=%h expected 1 %h",
               accepted.size(), inst_sram_addr, RESET_PC + 32'd4);
    end
    addr_ok = 1'b1; dok_rate = 100;
    repeat (8) cycle();
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (delivered.size() <= i || delivered[i] !== RESET_PC + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL stall_no_dup[%0d]: got %h expected %h", i,
                 delivered.size() > i ? delivered[i] : 32'hx, RESET_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) apply_reset();
      addr_ok    = ($urandom_range(99) < 70);
      id_allowin = ($urandom_range(99) < 60);
      dok_rate   = 60;
      r = $urandom_range(99);
      flush    = (r < 3) || (r == 50);
      br_taken = (r >= 3 && r < 7) || (r == 50);
      flush_target = $urandom & 32'hffff_fffc;
      br_target    = $urandom & 32'hffff_fffc;
      cycle();
    end
    flush = 1'b0; br_taken = 1'b0;
    tests_run++;
    if (delivered.size() < 50) begin
      tests_failed++;
      $display("FAIL random_progress: got %0d delivered expected >= 50", delivered.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reset();
    test_backpressure();
    test_branch_cancel();
    test_flush_priority();
    test_redirect_same_cycle();
    test_addr_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
